// File: rtl/md_pkg.sv
// Shared op codes, default latencies and FSM encodings for the MD issue controller.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;
   localparam logic [2:0] MD_MFHI  = 3'b110;
   localparam logic [2:0] MD_MFLO  = 3'b111;

   localparam int MD_MULT_LAT = 5;
   localparam int MD_DIV_LAT  = 10;
   localparam int MD_CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } md_state_e;

   // MULT/MULTU/DIV/DIVU are the ops that start the unit.
   function automatic logic md_is_start(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic md_is_mt(input logic [2:0] op);
      return (op[2:1] == 2'b10);
   endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Latency down-counter mirroring the MD unit; saturates at zero.
module md_lat_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   input  logic             clear,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (!hold) begin
         if (load) begin
            cnt_reg <= load_val;
         end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
         end
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Decodes MD ops in D, issues start/op/enable to the HI/LO unit from E, stalls D while a
// result is pending and requests HI/LO rollback when a flush hits an MD op in M.
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_LAT = MD_MULT_LAT,
   parameter int DIV_LAT  = MD_DIV_LAT,
   parameter int CNT_W    = MD_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       d_md_valid,
   input  logic [2:0] d_md_op,
   input  logic       pipe_freeze,
   input  logic       pipe_flush,
   input  logic       md_busy,
   output logic       stall_d,
   output logic       md_start,
   output logic [2:0] md_ctr,
   output logic       md_en,
   output logic       md_lock,
   output logic       rollback,
   output logic       md_err
);

   md_state_e  state_reg;
   logic       start_reg;
   logic       en_reg;
   logic       en_m_reg;
   logic       rollback_reg;
   logic       err_reg;
   logic [2:0] ctr_reg;

   logic             cnt_zero;
   logic             accept;
   logic             accept_start;
   logic             accept_mt;
   logic             cancel;
   logic [CNT_W-1:0] load_val;

   // No bypass: an op waiting in D goes on the edge after cnt==0 is visible.
   assign stall_d      = d_md_valid & (!cnt_zero | (state_reg == ST_ISSUE));
   assign accept       = d_md_valid & !stall_d & !pipe_freeze & !pipe_flush;
   assign accept_start = accept & md_is_start(d_md_op);
   assign accept_mt    = accept & md_is_mt(d_md_op);
   assign cancel       = pipe_flush & en_m_reg & !pipe_freeze;
   assign load_val     = d_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

   md_lat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept_start),
      .load_val (load_val),
      .hold     (pipe_freeze),
      .clear    (cancel),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         start_reg    <= 1'b0;
         en_reg       <= 1'b0;
         en_m_reg     <= 1'b0;
         rollback_reg <= 1'b0;
         err_reg      <= 1'b0;
         ctr_reg      <= 3'b000;
      end else begin
         if (!pipe_freeze) begin
            start_reg    <= accept_start;
            en_reg       <= accept_start | accept_mt;
            en_m_reg     <= en_reg;
            rollback_reg <= cancel;
            if (accept_start | accept_mt) begin
               ctr_reg <= d_md_op;
            end
            if (cancel) begin
               state_reg <= ST_IDLE;
            end else if (accept_start) begin
               state_reg <= ST_ISSUE;
            end else begin
               case (state_reg)
                  ST_ISSUE: state_reg <= ST_BUSY;
                  ST_BUSY:  if (cnt_zero) state_reg <= ST_IDLE;
                  default:  state_reg <= ST_IDLE;
               endcase
            end
         end
         // Busy lags start by one cycle, so ISSUE is exempt from the mismatch check.
         if (md_busy & cnt_zero & (state_reg != ST_ISSUE) & !pipe_freeze) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign md_start = start_reg;
   assign md_en    = en_reg;
   assign md_ctr   = ctr_reg;
   assign rollback = rollback_reg;
   assign md_err   = err_reg;
   assign md_lock  = pipe_freeze;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: issue latency, stalls, MT ops, cancel, freeze and reset.
module tb_md_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_md_valid;
   logic [2:0] d_md_op;
   logic       pipe_freeze;
   logic       pipe_flush;
   logic       md_busy;
   logic       stall_d;
   logic       md_start;
   logic [2:0] md_ctr;
   logic       md_en;
   logic       md_lock;
   logic       rollback;
   logic       md_err;

   int checks = 0;
   int errors = 0;

   md_issue_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .d_md_valid  (d_md_valid),
      .d_md_op     (d_md_op),
      .pipe_freeze (pipe_freeze),
      .pipe_flush  (pipe_flush),
      .md_busy     (md_busy),
      .stall_d     (stall_d),
      .md_start    (md_start),
      .md_ctr      (md_ctr),
      .md_en       (md_en),
      .md_lock     (md_lock),
      .rollback    (rollback),
      .md_err      (md_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("check %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Move into the next cycle; inputs are driven 2 time units after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic quiet_inputs();
      d_md_valid  = 1'b0;
      d_md_op     = 3'b000;
      pipe_freeze = 1'b0;
      pipe_flush  = 1'b0;
      md_busy     = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         quiet_inputs();
      end
   endtask

   task automatic drive_d(input logic valid, input logic [2:0] op);
      d_md_valid = valid;
      d_md_op    = op;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int stall_cnt;

      // ---- reset ----
      reset = 1'b0;
      quiet_inputs();
      next_cycle();
      next_cycle();
      check("rst_start", md_start, 0);
      check("rst_en", md_en, 0);
      check("rst_ctr", md_ctr, 3'b000);
      check("rst_rollback", rollback, 0);
      check("rst_err", md_err, 0);
      reset = 1'b1;
      drain(2);

      // ---- 1: MULT then MFHI; MD unit busy cycles 2..5 ----
      next_cycle();
      drive_d(1'b1, 3'b000);
      #1 check("t1_stall_c0", stall_d, 0);
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         drive_d(1'b1, 3'b110);
         md_busy = (c >= 2 && c <= 5);
         #1;
         check($sformatf("t1_stall_c%0d", c), stall_d, (c <= 5));
         check($sformatf("t1_start_c%0d", c), md_start, (c == 1));
         if (c == 1) check("t1_ctr", md_ctr, 3'b000);
         if (c == 1) check("t1_en", md_en, 1);
      end
      next_cycle();
      quiet_inputs();
      #1;
      check("t1_mfhi_no_en", md_en, 0);
      check("t1_mfhi_no_start", md_start, 0);
      check("t1_err", md_err, 0);
      drain(12);

      // ---- 2: DIVU then DIV back-to-back ----
      next_cycle();
      drive_d(1'b1, 3'b011);
      stall_cnt = 0;
      for (int c = 1; c <= 13; c++) begin
         next_cycle();
         drive_d(c <= 11, 3'b010);
         #1;
         if (stall_d) stall_cnt++;
         // first start at 1; DIV accepted in first cnt==0 cycle (11), starts at 12
         check($sformatf("t2_start_c%0d", c), md_start, (c == 1 || c == 12));
         if (c == 1) check("t2_ctr_divu", md_ctr, 3'b011);
         if (c == 12) check("t2_ctr_div", md_ctr, 3'b010);
      end
      check("t2_stall_cycles", stall_cnt, 10);
      drain(12);

      // ---- 3a: MTLO with cnt==0 ----
      next_cycle();
      drive_d(1'b1, 3'b101);
      #1 check("t3a_stall", stall_d, 0);
      next_cycle();
      quiet_inputs();
      #1;
      check("t3a_en", md_en, 1);
      check("t3a_ctr", md_ctr, 3'b101);
      check("t3a_start", md_start, 0);
      next_cycle();
      #1 check("t3a_en_drop", md_en, 0);
      drain(2);

      // ---- 3b: MTLO while DIV busy ----
      next_cycle();
      drive_d(1'b1, 3'b010);
      for (int c = 1; c <= 12; c++) begin
         next_cycle();
         drive_d(c <= 11, 3'b101);
         #1;
         if (c <= 11) check($sformatf("t3b_stall_c%0d", c), stall_d, (c <= 10));
         if (c == 12) begin
            check("t3b_en", md_en, 1);
            check("t3b_ctr", md_ctr, 3'b101);
            check("t3b_start", md_start, 0);
         end
      end
      drain(3);

      // ---- 4: flush one cycle after md_start cancels the MULT ----
      next_cycle();
      drive_d(1'b1, 3'b000);
      next_cycle();
      quiet_inputs();
      #1 check("t4_start", md_start, 1);
      next_cycle();
      pipe_flush = 1'b1;
      #1 check("t4_rb_before", rollback, 0);
      next_cycle();
      quiet_inputs();
      drive_d(1'b1, 3'b111);
      #1;
      check("t4_rollback", rollback, 1);
      check("t4_mflo_stall", stall_d, 0);
      next_cycle();
      quiet_inputs();
      #1;
      check("t4_rb_pulse", rollback, 0);
      check("t4_mflo_no_en", md_en, 0);
      drain(2);

      // ---- 4b: flush with nothing in M only blocks the accept ----
      next_cycle();
      drive_d(1'b1, 3'b000);
      next_cycle();
      quiet_inputs();
      pipe_flush = 1'b1;
      next_cycle();
      pipe_flush = 1'b0;
      drive_d(1'b1, 3'b110);
      #1;
      check("t4b_rollback", rollback, 0);
      check("t4b_still_stall", stall_d, 1);
      drain(8);

      // ---- 5: freeze for 3 cycles during BUSY ----
      next_cycle();
      drive_d(1'b1, 3'b000);
      for (int c = 1; c <= 10; c++) begin
         next_cycle();
         drive_d(c <= 9, 3'b110);
         pipe_freeze = (c >= 3 && c <= 5);
         #1;
         if (c <= 9) check($sformatf("t5_stall_c%0d", c), stall_d, (c <= 8));
         check($sformatf("t5_lock_c%0d", c), md_lock, (c >= 3 && c <= 5));
         if (c == 10) check("t5_mfhi_no_start", md_start, 0);
      end
      drain(3);

      // ---- 6: reset during DIV BUSY with a flush pending ----
      next_cycle();
      drive_d(1'b1, 3'b010);
      next_cycle();
      quiet_inputs();
      next_cycle();
      reset = 1'b0;
      pipe_flush = 1'b1;
      next_cycle();
      reset = 1'b1;
      quiet_inputs();
      drive_d(1'b1, 3'b110);
      #1;
      check("t6_start", md_start, 0);
      check("t6_en", md_en, 0);
      check("t6_ctr", md_ctr, 3'b000);
      check("t6_rollback", rollback, 0);
      check("t6_stall", stall_d, 0);
      next_cycle();
      quiet_inputs();
      md_busy = 1'b1;
      #1 check("t6_err_pre", md_err, 0);
      next_cycle();
      md_busy = 1'b0;
      #1 check("t6_err_set", md_err, 1);
      next_cycle();
      #1 check("t6_err_sticky", md_err, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
